// File: rtl/alu_rsp_unit.sv
// alu_rsp_unit: handshaked, registered 32-bit ALU responder.
// Accepts one command at a time on cmd_valid/cmd_ready and holds its result
// on rsp_valid/rsp_ready until consumed.
// Define ALU_RSP_MUL_EN to build the iterative shift-add multiplier (op 8).
// Without it op 8 is reported as illegal like ops 11-15.
module alu_rsp_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_carry,
  output logic             rsp_err
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOTA = 4'd5;
  localparam logic [3:0] OP_LSH  = 4'd6;
  localparam logic [3:0] OP_RSH  = 4'd7;
  localparam logic [3:0] OP_MOVA = 4'd9;
  localparam logic [3:0] OP_MOVB = 4'd10;

`ifdef ALU_RSP_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd8;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_RESP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RESP} state_t;
`endif

  state_t             state_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_y_q;
  logic               rsp_carry_q;
  logic               rsp_err_q;

  logic               accept;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_c;
  logic               alu_e;

`ifdef ALU_RSP_MUL_EN
  logic               is_mul;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [SW-1:0]      cnt_q;

  assign is_mul = (cmd_op == OP_MUL);
  // Partial product for the current multiplier bit (LSB first).
  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // A new command may enter when idle, or when the held response leaves this cycle.
  assign cmd_ready = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
  assign accept    = cmd_valid && cmd_ready;

  // Carry/borrow come from the extra top bit; shifts keep the last bit shifted
  // out in the extra bit (top for left, bottom for right), which is 0 for s=0.
  assign shamt = cmd_b[SW-1:0];
  assign add_w = {1'b0, cmd_a} + {1'b0, cmd_b};
  assign sub_w = {1'b0, cmd_a} - {1'b0, cmd_b};
  assign shl_w = {1'b0, cmd_a} << shamt;
  assign shr_w = {cmd_a, 1'b0} >> shamt;

  // Single-cycle result for every op except the iterative multiply.
  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_e = 1'b0;
    case (cmd_op)
      OP_ADD:  begin alu_y = add_w[WIDTH-1:0]; alu_c = add_w[WIDTH]; end
      OP_SUB:  begin alu_y = sub_w[WIDTH-1:0]; alu_c = sub_w[WIDTH]; end
      OP_AND:  alu_y = cmd_a & cmd_b;
      OP_OR:   alu_y = cmd_a | cmd_b;
      OP_XOR:  alu_y = cmd_a ^ cmd_b;
      OP_NOTA: alu_y = ~cmd_a;
      OP_LSH:  begin alu_y = shl_w[WIDTH-1:0]; alu_c = shl_w[WIDTH]; end
      OP_RSH:  begin alu_y = shr_w[WIDTH:1]; alu_c = shr_w[0]; end
      OP_MOVA: alu_y = cmd_a;
      OP_MOVB: alu_y = cmd_b;
      default: alu_e = 1'b1;
    endcase
  end

  // Control FSM with registered response outputs and multiplier datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
`ifdef ALU_RSP_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_RSP_MUL_EN
      if (is_mul) begin
        state_q     <= S_MUL;
        rsp_valid_q <= 1'b0;
        mcand_q     <= {{WIDTH{1'b0}}, cmd_a};
        mplier_q    <= cmd_b;
        acc_q       <= '0;
        cnt_q       <= '0;
      end else
`endif
      begin
        state_q     <= S_RESP;
        rsp_valid_q <= 1'b1;
        rsp_y_q     <= alu_y;
        rsp_carry_q <= alu_c;
        rsp_err_q   <= alu_e;
      end
    end else begin
      case (state_q)
`ifdef ALU_RSP_MUL_EN
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SW'(1);
          if (cnt_q == SW'(WIDTH - 1)) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_y_q     <= acc_d[WIDTH-1:0];
            rsp_carry_q <= |acc_d[2*WIDTH-1:WIDTH];
            rsp_err_q   <= 1'b0;
          end
        end
`endif
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_rsp_unit.sv
// Self-checking bench for alu_rsp_unit: transaction-level reference model,
// per-cycle compare process, directed literal cases and random traffic.
module tb_alu_rsp_unit;

  localparam int W = 32;

`ifdef ALU_RSP_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [3:0]   cmd_op = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_y;
  logic         rsp_carry;
  logic         rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_rsp_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from the arithmetic definitions, using 64-bit math.
  function automatic void ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] op, output logic [W-1:0] y,
                                  output logic c, output logic e);
    logic [63:0] wide;
    int s;
    s = int'(b[4:0]);
    y = '0; c = 1'b0; e = 1'b0;
    case (op)
      4'd0: begin wide = 64'(a) + 64'(b); y = wide[31:0]; c = wide[32]; end
      4'd1: begin y = a - b; c = (a < b); end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = ~a;
      4'd6: begin y = a << s; if (s != 0) c = a[W - s]; end
      4'd7: begin y = a >> s; if (s != 0) c = a[s - 1]; end
      4'd8: begin
        if (MUL_EN) begin
          wide = 64'(a) * 64'(b); y = wide[31:0]; c = (wide[63:32] != 0);
        end else e = 1'b1;
      end
      4'd9:  y = a;
      4'd10: y = b;
      default: e = 1'b1;
    endcase
  endfunction

  // Transaction model: a response appears 0 cycles (or W for MUL) after the
  // accepting edge and stays until taken; one outstanding command at most.
  logic         m_valid = 1'b0;
  int           m_wait = 0;
  logic [W-1:0] m_y = '0;
  logic         m_c = 1'b0;
  logic         m_e = 1'b0;
  logic         t_rdy;
  logic [W-1:0] t_y;
  logic         t_c;
  logic         t_e;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0;
      m_wait  = 0;
    end else begin
      t_rdy = (m_wait == 0 && !m_valid) || (m_valid && rsp_ready);
      if (m_valid && rsp_ready) m_valid = 1'b0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_valid = 1'b1;
      end
      if (t_rdy && cmd_valid) begin
        ref_alu(cmd_a, cmd_b, cmd_op, t_y, t_c, t_e);
        m_y = t_y; m_c = t_c; m_e = t_e;
        if (MUL_EN && cmd_op == 4'd8) m_wait = W;
        else m_valid = 1'b1;
      end
    end
  end

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", rsp_valid, 0);
      check("rst_y", rsp_y, 0);
      check("rst_carry", rsp_carry, 0);
      check("rst_err", rsp_err, 0);
    end else begin
      check("valid", rsp_valid, m_valid);
      check("cmd_ready", cmd_ready, (m_wait == 0 && !m_valid) || (m_valid && rsp_ready));
      if (m_valid) begin
        check("rsp_y", rsp_y, m_y);
        check("rsp_carry", rsp_carry, m_c);
        check("rsp_err", rsp_err, m_e);
        if (rsp_ready)
          $display("rsp: y=%08h carry=%0b err=%0b t=%0t", rsp_y, rsp_carry, rsp_err, $time);
      end
    end
  end

  // Directed op with literal expectations; busy = cycles with cmd_ready low
  // between accept and response (0 single-cycle, W for MUL).
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] op, input logic [W-1:0] ey, input logic ec,
                        input logic ee, input int ebusy);
    bit ok;
    int busy;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; rsp_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    check({name, "_accept"}, ok, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    busy = 0;
    @(negedge clk);
    while (!rsp_valid && busy < 100) begin
      busy++;
      @(negedge clk);
    end
    check({name, "_latency"}, busy, ebusy);
    check({name, "_y"}, rsp_y, ey);
    check({name, "_carry"}, rsp_carry, ec);
    check({name, "_err"}, rsp_err, ee);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] py;
    logic pc, pe;

    // Pin the model on a few hand-computed values.
    ref_alu(32'd32, 32'd56, 4'd1, py, pc, pe);
    check("model_sub", {pe, pc, py}, {1'b0, 1'b1, 32'hFFFFFFE8});
    ref_alu(32'h80000001, 32'd1, 4'd6, py, pc, pe);
    check("model_lsh", {pe, pc, py}, {1'b0, 1'b1, 32'h00000002});
    ref_alu(32'h80000001, 32'd1, 4'd7, py, pc, pe);
    check("model_rsh", {pe, pc, py}, {1'b0, 1'b1, 32'h40000000});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    check("post_rst_valid", rsp_valid, 0);

    run_op("add", 32'd56, 32'd32, 4'd0, 32'd88, 1'b0, 1'b0, 0);
    run_op("sub", 32'd56, 32'd32, 4'd1, 32'd24, 1'b0, 1'b0, 0);
    run_op("sub_borrow", 32'd32, 32'd56, 4'd1, 32'hFFFFFFE8, 1'b1, 1'b0, 0);
    run_op("add_carry", 32'hFFFFFFFF, 32'd1, 4'd0, 32'd0, 1'b1, 1'b0, 0);
    run_op("lsh", 32'h80000001, 32'd1, 4'd6, 32'h00000002, 1'b1, 1'b0, 0);
    run_op("rsh", 32'h80000001, 32'd1, 4'd7, 32'h40000000, 1'b1, 1'b0, 0);
    run_op("lsh0", 32'h80000001, 32'd0, 4'd6, 32'h80000001, 1'b0, 1'b0, 0);
    run_op("rsh0", 32'h80000001, 32'd0, 4'd7, 32'h80000001, 1'b0, 1'b0, 0);
    run_op("nota", 32'h0F0F0F0F, 32'd3, 4'd5, 32'hF0F0F0F0, 1'b0, 1'b0, 0);
    run_op("illegal15", 32'd5, 32'd6, 4'd15, 32'd0, 1'b0, 1'b1, 0);
`ifdef ALU_RSP_MUL_EN
    run_op("mul", 32'd56, 32'd32, 4'd8, 32'd1792, 1'b0, 1'b0, W);
    run_op("mul_ovf", 32'hFFFFFFFF, 32'd2, 4'd8, 32'hFFFFFFFE, 1'b1, 1'b0, W);
`else
    run_op("mul_off", 32'd56, 32'd32, 4'd8, 32'd0, 1'b0, 1'b1, 0);
`endif

    // Backpressure: OR result held for 5 cycles, then back-to-back MOV A / MOV B.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = 32'd56; cmd_b = 32'd32; cmd_op = 4'd3; rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_y", rsp_y, 32'd56);
      check("bp_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 4'd9;
    @(negedge clk);
    check("b2b_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_op = 4'd10;
    @(negedge clk);
    check("b2b_mova", rsp_y, 32'd56);
    check("b2b_mova_valid", rsp_valid, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_movb", rsp_y, 32'd32);

    // Reset while a response is held.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = 32'hF0; cmd_b = 32'h0F; cmd_op = 4'd4; rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_resp_valid", rsp_valid, 0);
    check("rst_resp_y", rsp_y, 0);
    @(posedge clk); #1;
    rst = 1'b0;

`ifdef ALU_RSP_MUL_EN
    // Reset 10 cycles into a multiply.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = 32'd7; cmd_b = 32'd9; cmd_op = 4'd8; rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_mul_valid", rsp_valid, 0);
    check("rst_mul_y", rsp_y, 0);
    check("rst_mul_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
`endif
    run_op("illegal12", 32'd123, 32'd45, 4'd12, 32'd0, 1'b0, 1'b1, 0);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = ($urandom_range(0, 9) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      cmd_a     = pick();
      cmd_b     = pick();
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    check("drain_idle", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_rsp_unit.md
# alu_rsp_unit

Handshaked, registered responder for the 32-bit ALU operation set (op codes 0–10). Accepts one command at a time on a valid/ready channel, computes the result (single cycle, or iteratively for MUL), and holds the result on a valid/ready response channel until it is consumed. It sits between an op-issuing master (sequencer or bench) and downstream logic that needs registered, flow-controlled ALU results.

## Interface
- WIDTH, 32, operand/result width; shift amount uses B[$clog2(WIDTH)-1:0]
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on clk edge when cmd_valid && cmd_ready
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- cmd_op  in  4  op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 LSHIFT, 7 RSHIFT, 8 MUL, 9 MOV A, 10 MOV B
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed on clk edge when rsp_valid && rsp_ready
- rsp_y  out  WIDTH  result
- rsp_carry  out  1  carry/flag (see Operation)
- rsp_err  out  1  illegal or compiled-out op

## Operation
- States: IDLE, MUL, RESP.
- IDLE: cmd_ready=1. On accept: non-MUL op → compute, register into rsp_*, go RESP. MUL → latch operands, clear accumulator and counter, go MUL.
- MUL: shift-add, one multiplier bit (LSB first) per cycle, counter 0..WIDTH-1; after WIDTH iterations load result, go RESP. cmd_ready=0.
- RESP: rsp_valid=1; rsp_y/rsp_carry/rsp_err stable until handshake. On handshake: if cmd_valid same cycle, accept new command (same rules as IDLE); else go IDLE.
- cmd_ready = (state==IDLE) || (state==RESP && rsp_ready). Combinational from rsp_ready only.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: y=A+B; carry=carry-out of bit WIDTH-1.
  - SUB: y=A-B; carry=1 iff A<B unsigned (borrow).
  - AND/OR/XOR/NOT A/MOV A/MOV B: carry=0.
  - LSHIFT: y=A<<s, RSHIFT: y=A>>s (logical), s=B[$clog2(WIDTH)-1:0]; carry=last bit shifted out; s=0 → carry=0.
  - MUL: y=low WIDTH bits of unsigned A*B; carry=1 iff high WIDTH bits nonzero.
  - Op 11–15: y=0, carry=0, err=1, single-cycle.
- rsp_err=0 for every legal op.

## Timing
- Reset (async, immediate): state=IDLE, rsp_valid=0, rsp_y=0, rsp_carry=0, rsp_err=0, cmd_ready=1 after reset deassertion; MUL counter/accumulator cleared.
- Non-MUL latency: accepted at edge N → rsp_valid=1 after edge N.
- MUL latency: accepted at edge N → rsp_valid=1 after edge N+WIDTH (N+32 by default).
- Peak throughput one non-MUL op per cycle with rsp_ready held high.
- Backpressure: rsp_ready=0 holds RESP indefinitely; no command accepted, outputs unchanged.
- Reset mid-MUL or mid-RESP: in-flight result discarded, no response emitted.
- cmd_* ignored when cmd_ready=0; no buffering beyond one response.

## Configuration
- ALU_RSP_MUL_EN defined: op 8 implemented as iterative MUL above (MUL state present).
- Not defined: no MUL state or multiplier datapath; op 8 treated as illegal: single-cycle, y=0, carry=0, err=1.

## Test plan
- A=56, B=32, op=0, rsp_ready=1 → next edge rsp_y=88, carry=0, err=0; op=1 → rsp_y=24, carry=0.
- A=32, B=56, op=1 → rsp_y=0xFFFFFFE8, carry=1; A=0xFFFFFFFF, B=1, op=0 → rsp_y=0, carry=1.
- A=0x80000001, B=1, op=6 → rsp_y=0x00000002, carry=1; op=7 → rsp_y=0x40000000, carry=1; B=0 → y=A, carry=0.
- With ALU_RSP_MUL_EN: A=56, B=32, op=8 → cmd_ready=0 for 32 cycles, rsp_y=1792, carry=0; A=0xFFFFFFFF, B=2 → rsp_y=0xFFFFFFFE, carry=1. Without macro: op=8 → y=0, err=1 next edge.
- rsp_ready=0 for 5 cycles after op=3 (A=56, B=32): rsp_y=56 held, cmd_ready=0; then rsp_ready=1 with cmd_valid op=9 → back-to-back accept, rsp_y=56 (MOV A) next edge.
- rst asserted 10 cycles into a MUL → rsp_valid=0, outputs 0 immediately; after release op=12 → y=0, err=1.
